// File: rtl/aes_128_if.sv
// Block/key/ciphertext bundle for the pipelined AES-128 core.
// AES_128_VALID_EN adds in_valid/out_valid sideband qualifiers.
interface aes_128_if;
  logic [127:0] state;
  logic [127:0] key;
  logic [127:0] out;
`ifdef AES_128_VALID_EN
  logic         in_valid;
  logic         out_valid;
`endif

`ifdef AES_128_VALID_EN
  modport master (output state, output key, output in_valid, input out, input out_valid);
  modport slave  (input state, input key, input in_valid, output out, output out_valid);
`else
  modport master (output state, output key, input out);
  modport slave  (input state, input key, output out);
`endif
endinterface

// File: rtl/aes_128.sv
// Fully pipelined AES-128 encryptor: stage 0 whitening plus ten registered rounds.
// AES_128_VALID_EN adds an 11-deep valid shift register alongside the data.
module aes_128 (
  input  logic     clk,
  input  logic     rst_n,
  aes_128_if.slave bus
);

  localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] v;
    case (b)
      8'h00: v = 8'h63; 8'h01: v = 8'h7c; 8'h02: v = 8'h77; 8'h03: v = 8'h7b; 8'h04: v = 8'hf2; 8'h05: v = 8'h6b; 8'h06: v = 8'h6f; 8'h07: v = 8'hc5;
      8'h08: v = 8'h30; 8'h09: v = 8'h01; 8'h0a: v = 8'h67; 8'h0b: v = 8'h2b; 8'h0c: v = 8'hfe; 8'h0d: v = 8'hd7; 8'h0e: v = 8'hab; 8'h0f: v = 8'h76;
      8'h10: v = 8'hca; 8'h11: v = 8'h82; 8'h12: v = 8'hc9; 8'h13: v = 8'h7d; 8'h14: v = 8'hfa; 8'h15: v = 8'h59; 8'h16: v = 8'h47; 8'h17: v = 8'hf0;
      8'h18: v = 8'had; 8'h19: v = 8'hd4; 8'h1a: v = 8'ha2; 8'h1b: v = 8'haf; 8'h1c: v = 8'h9c; 8'h1d: v = 8'ha4; 8'h1e: v = 8'h72; 8'h1f: v = 8'hc0;
      8'h20: v = 8'hb7; 8'h21: v = 8'hfd; 8'h22: v = 8'h93; 8'h23: v = 8'h26; 8'h24: v = 8'h36; 8'h25: v = 8'h3f; 8'h26: v = 8'hf7; 8'h27: v = 8'hcc;
      8'h28: v = 8'h34; 8'h29: v = 8'ha5; 8'h2a: v = 8'he5; 8'h2b: v = 8'hf1; 8'h2c: v = 8'h71; 8'h2d: v = 8'hd8; 8'h2e: v = 8'h31; 8'h2f: v = 8'h15;
      8'h30: v = 8'h04; 8'h31: v = 8'hc7; 8'h32: v = 8'h23; 8'h33: v = 8'hc3; 8'h34: v = 8'h18; 8'h35: v = 8'h96; 8'h36: v = 8'h05; 8'h37: v = 8'h9a;
      8'h38: v = 8'h07; 8'h39: v = 8'h12; 8'h3a: v = 8'h80; 8'h3b: v = 8'he2; 8'h3c: v = 8'heb; 8'h3d: v = 8'h27; 8'h3e: v = 8'hb2; 8'h3f: v = 8'h75;
      8'h40: v = 8'h09; 8'h41: v = 8'h83; 8'h42: v = 8'h2c; 8'h43: v = 8'h1a; 8'h44: v = 8'h1b; 8'h45: v = 8'h6e; 8'h46: v = 8'h5a; 8'h47: v = 8'ha0;
      8'h48: v = 8'h52; 8'h49: v = 8'h3b; 8'h4a: v = 8'hd6; 8'h4b: v = 8'hb3; 8'h4c: v = 8'h29; 8'h4d: v = 8'he3; 8'h4e: v = 8'h2f; 8'h4f: v = 8'h84;
      8'h50: v = 8'h53; 8'h51: v = 8'hd1; 8'h52: v = 8'h00; 8'h53: v = 8'hed; 8'h54: v = 8'h20; 8'h55: v = 8'hfc; 8'h56: v = 8'hb1; 8'h57: v = 8'h5b;
      8'h58: v = 8'h6a; 8'h59: v = 8'hcb; 8'h5a: v = 8'hbe; 8'h5b: v = 8'h39; 8'h5c: v = 8'h4a; 8'h5d: v = 8'h4c; 8'h5e: v = 8'h58; 8'h5f: v = 8'hcf;
      8'h60: v = 8'hd0; 8'h61: v = 8'hef; 8'h62: v = 8'haa; 8'h63: v = 8'hfb; 8'h64: v = 8'h43; 8'h65: v = 8'h4d; 8'h66: v = 8'h33; 8'h67: v = 8'h85;
      8'h68: v = 8'h45; 8'h69: v = 8'hf9; 8'h6a: v = 8'h02; 8'h6b: v = 8'h7f; 8'h6c: v = 8'h50; 8'h6d: v = 8'h3c; 8'h6e: v = 8'h9f; 8'h6f: v = 8'ha8;
      8'h70: v = 8'h51; 8'h71: v = 8'ha3; 8'h72: v = 8'h40; 8'h73: v = 8'h8f; 8'h74: v = 8'h92; 8'h75: v = 8'h9d; 8'h76: v = 8'h38; 8'h77: v = 8'hf5;
      8'h78: v = 8'hbc; 8'h79: v = 8'hb6; 8'h7a: v = 8'hda; 8'h7b: v = 8'h21; 8'h7c: v = 8'h10; 8'h7d: v = 8'hff; 8'h7e: v = 8'hf3; 8'h7f: v = 8'hd2;
      8'h80: v = 8'hcd; 8'h81: v = 8'h0c; 8'h82: v = 8'h13; 8'h83: v = 8'hec; 8'h84: v = 8'h5f; 8'h85: v = 8'h97; 8'h86: v = 8'h44; 8'h87: v = 8'h17;
      8'h88: v = 8'hc4; 8'h89: v = 8'ha7; 8'h8a: v = 8'h7e; 8'h8b: v = 8'h3d; 8'h8c: v = 8'h64; 8'h8d: v = 8'h5d; 8'h8e: v = 8'h19; 8'h8f: v = 8'h73;
      8'h90: v = 8'h60; 8'h91: v = 8'h81; 8'h92: v = 8'h4f; 8'h93: v = 8'hdc; 8'h94: v = 8'h22; 8'h95: v = 8'h2a; 8'h96: v = 8'h90; 8'h97: v = 8'h88;
      8'h98: v = 8'h46; 8'h99: v = 8'hee; 8'h9a: v = 8'hb8; 8'h9b: v = 8'h14; 8'h9c: v = 8'hde; 8'h9d: v = 8'h5e; 8'h9e: v = 8'h0b; 8'h9f: v = 8'hdb;
      8'ha0: v = 8'he0; 8'ha1: v = 8'h32; 8'ha2: v = 8'h3a; 8'ha3: v = 8'h0a; 8'ha4: v = 8'h49; 8'ha5: v = 8'h06; 8'ha6: v = 8'h24; 8'ha7: v = 8'h5c;
      8'ha8: v = 8'hc2; 8'ha9: v = 8'hd3; 8'haa: v = 8'hac; 8'hab: v = 8'h62; 8'hac: v = 8'h91; 8'had: v = 8'h95; 8'hae: v = 8'he4; 8'haf: v = 8'h79;
      8'hb0: v = 8'he7; 8'hb1: v = 8'hc8; 8'hb2: v = 8'h37; 8'hb3: v = 8'h6d; 8'hb4: v = 8'h8d; 8'hb5: v = 8'hd5; 8'hb6: v = 8'h4e; 8'hb7: v = 8'ha9;
      8'hb8: v = 8'h6c; 8'hb9: v = 8'h56; 8'hba: v = 8'hf4; 8'hbb: v = 8'hea; 8'hbc: v = 8'h65; 8'hbd: v = 8'h7a; 8'hbe: v = 8'hae; 8'hbf: v = 8'h08;
      8'hc0: v = 8'hba; 8'hc1: v = 8'h78; 8'hc2: v = 8'h25; 8'hc3: v = 8'h2e; 8'hc4: v = 8'h1c; 8'hc5: v = 8'ha6; 8'hc6: v = 8'hb4; 8'hc7: v = 8'hc6;
      8'hc8: v = 8'he8; 8'hc9: v = 8'hdd; 8'hca: v = 8'h74; 8'hcb: v = 8'h1f; 8'hcc: v = 8'h4b; 8'hcd: v = 8'hbd; 8'hce: v = 8'h8b; 8'hcf: v = 8'h8a;
      8'hd0: v = 8'h70; 8'hd1: v = 8'h3e; 8'hd2: v = 8'hb5; 8'hd3: v = 8'h66; 8'hd4: v = 8'h48; 8'hd5: v = 8'h03; 8'hd6: v = 8'hf6; 8'hd7: v = 8'h0e;
      8'hd8: v = 8'h61; 8'hd9: v = 8'h35; 8'hda: v = 8'h57; 8'hdb: v = 8'hb9; 8'hdc: v = 8'h86; 8'hdd: v = 8'hc1; 8'hde: v = 8'h1d; 8'hdf: v = 8'h9e;
      8'he0: v = 8'he1; 8'he1: v = 8'hf8; 8'he2: v = 8'h98; 8'he3: v = 8'h11; 8'he4: v = 8'h69; 8'he5: v = 8'hd9; 8'he6: v = 8'h8e; 8'he7: v = 8'h94;
      8'he8: v = 8'h9b; 8'he9: v = 8'h1e; 8'hea: v = 8'h87; 8'heb: v = 8'he9; 8'hec: v = 8'hce; 8'hed: v = 8'h55; 8'hee: v = 8'h28; 8'hef: v = 8'hdf;
      8'hf0: v = 8'h8c; 8'hf1: v = 8'ha1; 8'hf2: v = 8'h89; 8'hf3: v = 8'h0d; 8'hf4: v = 8'hbf; 8'hf5: v = 8'he6; 8'hf6: v = 8'h42; 8'hf7: v = 8'h68;
      8'hf8: v = 8'h41; 8'hf9: v = 8'h99; 8'hfa: v = 8'h2d; 8'hfb: v = 8'h0f; 8'hfc: v = 8'hb0; 8'hfd: v = 8'h54; 8'hfe: v = 8'hbb; 8'hff: v = 8'h16;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int n = 0; n < 16; n++) o[127-8*n -: 8] = sbox(s[127-8*n -: 8]);
    return o;
  endfunction

  // Byte n sits at row n%4, column n/4; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    int src;
    o = 128'h0;
    for (int n = 0; n < 16; n++) begin
      src = 4 * (((n / 4) + (n % 4)) % 4) + (n % 4);
      o[127-8*n -: 8] = s[127-8*src -: 8];
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  logic [127:0] s_r     [0:10];
  logic [127:0] k_r     [0:9];
  logic [127:0] s_nxt_s [1:10];
  logic [127:0] k_nxt_s [1:10];

  // Round logic: key schedule runs beside each round; the last round skips MixColumns.
  always_comb begin
    for (int r = 1; r <= 10; r++) begin
      k_nxt_s[r] = key_expand(k_r[r-1], RCON[r]);
      if (r < 10) begin
        s_nxt_s[r] = mix_columns(shift_rows(sub_bytes(s_r[r-1]))) ^ k_nxt_s[r];
      end else begin
        s_nxt_s[r] = shift_rows(sub_bytes(s_r[r-1])) ^ k_nxt_s[r];
      end
    end
  end

  // Pipeline registers; every block carries its own key so keys may change per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= 10; i++) s_r[i] <= 128'h0;
      for (int i = 0; i <= 9; i++) k_r[i] <= 128'h0;
    end else begin
      s_r[0] <= bus.state ^ bus.key;
      k_r[0] <= bus.key;
      for (int i = 1; i <= 10; i++) s_r[i] <= s_nxt_s[i];
      for (int i = 1; i <= 9; i++) k_r[i] <= k_nxt_s[i];
    end
  end

  assign bus.out = s_r[10];

`ifdef AES_128_VALID_EN
  logic [10:0] vld_r;

  // Valid tag tracks each block through the same 11 stages as its data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r <= 11'h000;
    end else begin
      vld_r <= {vld_r[9:0], bus.in_valid};
    end
  end

  assign bus.out_valid = vld_r[10];
`endif

endmodule

// File: tb/tb_aes_128.sv
// Directed-vector bench for aes_128: FIPS-197 vectors, streaming, async reset, latency.
module tb_aes_128;
  logic clk = 1'b0;
  logic rst_n;
  aes_128_if bus();

  aes_128 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [127:0] pt, input logic [127:0] k, input logic v);
    bus.state = pt;
    bus.key   = k;
`ifdef AES_128_VALID_EN
    bus.in_valid = v;
`else
    if (v) begin end
`endif
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ne(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs !== exp) else begin
      bad++;
      $error("FAIL %s observed=%h must differ from %h", tag, obs, exp);
    end
  endtask

  task automatic chk_v(input string tag, input logic exp);
`ifdef AES_128_VALID_EN
    total++;
    assert (bus.out_valid === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, bus.out_valid, exp);
    end
`else
    if (tag.len() == 0 && exp) begin end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    drive(128'h0, 128'h0, 1'b0);
    step(2);
    chk("reset_out", bus.out, 128'h0);
    chk_v("reset_vld", 1'b0);

    // Single block (appendix B) followed by all-zero inputs.
    rst_n = 1'b1;
    drive(PT_B, KEY_B, 1'b1);
    step(1);
    drive(128'h0, 128'h0, 1'b0);
    step(9);
    chk_ne("latency_early", bus.out, CT_B);
    step(1);
    chk("fips_b", bus.out, CT_B);
    chk_v("fips_b_vld", 1'b1);
    step(1);
    chk("all_zero", bus.out, CT_Z);
    chk_v("all_zero_vld", 1'b0);

    // Back-to-back stream with a different key every cycle; valid pattern 1,0,1.
    drive(PT_C, KEY_C, 1'b1);      step(1);
    drive(128'h0, 128'h0, 1'b0);   step(1);
    drive(PT_B, KEY_B, 1'b1);      step(1);
    drive(PT_C, KEY_C, 1'b0);      step(1);
    drive(128'h0, 128'h0, 1'b0);   step(1);
    drive(PT_B, KEY_B, 1'b0);      step(1);
    drive(128'h0, 128'h0, 1'b0);
    step(5);
    chk("stream0_c", bus.out, CT_C);  chk_v("stream0_vld", 1'b1); step(1);
    chk("stream1_z", bus.out, CT_Z);  chk_v("stream1_vld", 1'b0); step(1);
    chk("stream2_b", bus.out, CT_B);  chk_v("stream2_vld", 1'b1); step(1);
    chk("stream3_c", bus.out, CT_C);  chk_v("stream3_vld", 1'b0); step(1);
    chk("stream4_z", bus.out, CT_Z);  step(1);
    chk("stream5_b", bus.out, CT_B);

    // Mid-stream asynchronous reset, then latency from the first post-release sample.
    drive(PT_B, KEY_B, 1'b1);
    step(3);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", bus.out, 128'h0);
    chk_v("async_reset_vld", 1'b0);
    step(1);
    chk("reset_hold", bus.out, 128'h0);
    rst_n = 1'b1;
    drive(PT_C, KEY_C, 1'b1);
    step(10);
    chk_ne("post_reset_early", bus.out, CT_C);
    chk_v("post_reset_early_vld", 1'b0);
    step(1);
    chk("post_reset_c", bus.out, CT_C);
    chk_v("post_reset_vld", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
